// File: rtl/linreg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | linreg_pkg: shared types, defaults and saturating add for the error path  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package linreg_pkg;

  localparam int W_DEF    = 20;
  localparam int FRAC_DEF = 10;
  localparam int ONE      = 1 << FRAC_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Signed add clamped to a w-bit two's complement range; sat flags a clamp.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    sum   = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.sat = (sum > hi) || (sum < lo);
    r.val = (sum > hi) ? hi : ((sum < lo) ? lo : sum);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/linreg_error_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | linreg_error_accum_if: sample stream in, error stream and totals out      |
// | Revision: 1.0   (sse present only when LINREG_SSE_EN is defined)          |
// +--------------------------------------------------------------------------+
interface linreg_error_accum_if #(
  parameter int W     = linreg_pkg::W_DEF,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic                    start;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [W-1:0]     x;
  logic signed [W-1:0]     y;
  logic signed [W-1:0]     b0;
  logic signed [W-1:0]     b1;
  logic                    err_valid;
  logic signed [W-1:0]     err;
  logic signed [ACC_W-1:0] sum_e;
  logic signed [ACC_W-1:0] sum_ex;
  logic [CNT_W-1:0]        count;
  logic                    ovf;
  logic                    done;
`ifdef LINREG_SSE_EN
  logic signed [ACC_W-1:0] sse;

  modport master (
    output start, in_valid, in_last, x, y, b0, b1,
    input  in_ready, err_valid, err, sum_e, sum_ex, count, ovf, done, sse
  );
  modport slave (
    input  start, in_valid, in_last, x, y, b0, b1,
    output in_ready, err_valid, err, sum_e, sum_ex, count, ovf, done, sse
  );
`else
  modport master (
    output start, in_valid, in_last, x, y, b0, b1,
    input  in_ready, err_valid, err, sum_e, sum_ex, count, ovf, done
  );
  modport slave (
    input  start, in_valid, in_last, x, y, b0, b1,
    output in_ready, err_valid, err, sum_e, sum_ex, count, ovf, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/linreg_fxp_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | linreg_fxp_mul: registered signed WxW multiply, result >>> FRAC           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module linreg_fxp_mul #(
  parameter int W     = 20,
  parameter int FRAC  = 10,
  parameter int OUT_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     b_i,
  output logic signed [OUT_W-1:0] p_o
);
  logic signed [2*W-1:0]   prod;
  logic signed [OUT_W-1:0] p_q;

  assign prod = a_i * b_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_q <= '0;
    else       p_q <= OUT_W'(prod >>> FRAC);
  end

  assign p_o = p_q;
endmodule
`default_nettype wire

// File: rtl/linreg_error_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | linreg_error_accum: pipelined e = y-(b0+b1*x) with saturating epoch sums  |
// | Revision: 1.0   (LINREG_SSE_EN adds the sum-of-squared-error output)      |
// +--------------------------------------------------------------------------+
module linreg_error_accum
  import linreg_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  linreg_error_accum_if.slave bus
);
  localparam int PW = 2 * W - FRAC;

  state_e                  state_q, state_d;
  logic                    in_ready, accept;
  logic                    s1_v_q, err_v_q;
  logic signed [W-1:0]     b0_q, y_q, x_q, err_q, bx, err_d;
  logic signed [PW-1:0]    ex;
  logic signed [ACC_W-1:0] sum_e_q, sum_ex_q;
  logic [CNT_W-1:0]        count_q;
  logic                    ovf_q, cnt_sat, sse_sat;
  sat_res_t                add_e, add_ex;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = bus.in_valid & in_ready;

  linreg_fxp_mul #(.W(W), .FRAC(FRAC), .OUT_W(W)) u_mul_bx (
    .clk(clk), .reset(reset), .a_i(bus.b1), .b_i(bus.x), .p_o(bx)
  );

  assign err_d = y_q - (b0_q + bx);

  // e*x is formed from the S2 error so its product lands alongside err_q.
  linreg_fxp_mul #(.W(W), .FRAC(FRAC), .OUT_W(PW)) u_mul_ex (
    .clk(clk), .reset(reset), .a_i(err_d), .b_i(x_q), .p_o(ex)
  );

  assign add_e   = sat_add(64'(sum_e_q), 64'(err_q), ACC_W);
  assign add_ex  = sat_add(64'(sum_ex_q), 64'(ex), ACC_W);
  assign cnt_sat = &count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_RUN:   if (accept && bus.in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_v_q && !err_v_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.start) state_d = ST_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q  <= 1'b0;
      err_v_q <= 1'b0;
      b0_q    <= '0;
      y_q     <= '0;
      x_q     <= '0;
      err_q   <= '0;
    end else begin
      s1_v_q  <= accept & ~bus.start;
      err_v_q <= s1_v_q & ~bus.start;
      if (accept) begin
        b0_q <= bus.b0;
        y_q  <= bus.y;
        x_q  <= bus.x;
      end
      if (s1_v_q) err_q <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_e_q  <= '0;
      sum_ex_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (bus.start) begin
      sum_e_q  <= '0;
      sum_ex_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (err_v_q) begin
      sum_e_q  <= ACC_W'(add_e.val);
      sum_ex_q <= ACC_W'(add_ex.val);
      count_q  <= cnt_sat ? count_q : count_q + CNT_W'(1);
      ovf_q    <= ovf_q | add_e.sat | add_ex.sat | cnt_sat | sse_sat;
    end
  end

`ifdef LINREG_SSE_EN
  logic signed [PW-1:0]    ee;
  logic signed [ACC_W-1:0] sse_q;
  sat_res_t                add_ee;

  linreg_fxp_mul #(.W(W), .FRAC(FRAC), .OUT_W(PW)) u_mul_ee (
    .clk(clk), .reset(reset), .a_i(err_d), .b_i(err_d), .p_o(ee)
  );

  assign add_ee  = sat_add(64'(sse_q), 64'(ee), ACC_W);
  assign sse_sat = add_ee.sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          sse_q <= '0;
    else if (bus.start) sse_q <= '0;
    else if (err_v_q)   sse_q <= ACC_W'(add_ee.val);
  end

  assign bus.sse = sse_q;
`else
  assign sse_sat = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.err_valid = err_v_q;
  assign bus.err       = err_q;
  assign bus.sum_e     = sum_e_q;
  assign bus.sum_ex    = sum_ex_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
  assign bus.done      = (state_q == ST_DONE);
endmodule
`default_nettype wire
